// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver with a set-2 scan-code decoder for the space and arrow keys.
// Define PS2_TIMEOUT_EN to enable the mid-frame watchdog that aborts stalled frames.
`timescale 1ns/1ps

module ps2_key_decoder #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 40_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_space,
    output logic       key_left,
    output logic       key_right,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err
);

    localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);

    localparam logic [7:0] CodeExt   = 8'hE0;
    localparam logic [7:0] CodeBrk   = 8'hF0;
    localparam logic [7:0] CodeSpace = 8'h29;
    localparam logic [7:0] CodeLeft  = 8'h6B;
    localparam logic [7:0] CodeRight = 8'h74;

    typedef enum logic [1:0] {
        StIdle,
        StExt,
        StBrk,
        StExtBrk
    } state_e;

    // ------------------------------------------------------------------
    // Input synchronisers (idle-high bus, so reset to 1)
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   clk_s;
    logic                   data_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
        end
    end

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Clock glitch filter
    // ------------------------------------------------------------------
    logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
    logic             filt_q, filt_d;
    logic             sample_evt;

    always_comb begin
        filt_cnt_d = '0;
        filt_d     = filt_q;
        if (clk_s != filt_q) begin
            if (filt_cnt_q == FiltW'(FILTER_LEN - 1)) begin
                filt_d = clk_s;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_cnt_q <= '0;
            filt_q     <= 1'b1;
        end else begin
            filt_cnt_q <= filt_cnt_d;
            filt_q     <= filt_d;
        end
    end

    assign sample_evt = filt_q & ~filt_d;

    // ------------------------------------------------------------------
    // Frame assembly: shift_q[0] = start, [8:1] = data, [9] = parity
    // ------------------------------------------------------------------
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [9:0] shift_q, shift_d;
    logic [7:0] scan_code_q, scan_code_d;
    logic       scan_valid_q, scan_valid_d;
    logic       frame_err_q, frame_err_d;
    logic       frame_ok;

    assign frame_ok = ~shift_q[0] & data_s & (^shift_q[9:1]);

`ifdef PS2_TIMEOUT_EN
    localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WdW-1:0] wd_q, wd_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        scan_code_d  = scan_code_q;
        scan_valid_d = 1'b0;
        frame_err_d  = 1'b0;
`ifdef PS2_TIMEOUT_EN
        wd_d         = '0;
`endif
        if (sample_evt) begin
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_d = 4'd0;
                if (frame_ok) begin
                    scan_code_d  = shift_q[8:1];
                    scan_valid_d = 1'b1;
                end else begin
                    frame_err_d = 1'b1;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
                shift_d   = {data_s, shift_q[9:1]};
            end
        end
`ifdef PS2_TIMEOUT_EN
        else if (bit_cnt_q != 4'd0) begin
            if (wd_q == WdW'(TIMEOUT_CYCLES - 1)) begin
                bit_cnt_d   = 4'd0;
                frame_err_d = 1'b1;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q    <= 4'd0;
            shift_q      <= '0;
            scan_code_q  <= 8'h00;
            scan_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            scan_code_q  <= scan_code_d;
            scan_valid_q <= scan_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

`ifdef PS2_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Prefix decoder and key state
    // ------------------------------------------------------------------
    state_e state_q, state_d;
    logic   space_q, space_d;
    logic   left_q, left_d;
    logic   right_q, right_d;
    logic   act_valid;
    logic   act_make;
    logic   act_ext;

    always_comb begin
        state_d   = state_q;
        act_valid = 1'b0;
        act_make  = 1'b0;
        act_ext   = 1'b0;
        if (frame_err_q) begin
            state_d = StIdle;
        end else if (scan_valid_q) begin
            unique case (state_q)
                StIdle: begin
                    if (scan_code_q == CodeExt) begin
                        state_d = StExt;
                    end else if (scan_code_q == CodeBrk) begin
                        state_d = StBrk;
                    end else begin
                        act_valid = 1'b1;
                        act_make  = 1'b1;
                    end
                end
                StExt: begin
                    if (scan_code_q == CodeBrk) begin
                        state_d = StExtBrk;
                    end else if (scan_code_q == CodeExt) begin
                        state_d = StExt;
                    end else begin
                        act_valid = 1'b1;
                        act_make  = 1'b1;
                        act_ext   = 1'b1;
                        state_d   = StIdle;
                    end
                end
                StBrk: begin
                    act_valid = 1'b1;
                    state_d   = StIdle;
                end
                StExtBrk: begin
                    act_valid = 1'b1;
                    act_ext   = 1'b1;
                    state_d   = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Keypad 4/6 share codes with the arrows, so the extended flag must match too.
    always_comb begin
        space_d = space_q;
        left_d  = left_q;
        right_d = right_q;
        if (act_valid) begin
            if (!act_ext && scan_code_q == CodeSpace) begin
                space_d = act_make;
            end
            if (act_ext && scan_code_q == CodeLeft) begin
                left_d = act_make;
            end
            if (act_ext && scan_code_q == CodeRight) begin
                right_d = act_make;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            space_q <= 1'b0;
            left_q  <= 1'b0;
            right_q <= 1'b0;
        end else begin
            state_q <= state_d;
            space_q <= space_d;
            left_q  <= left_d;
            right_q <= right_d;
        end
    end

    assign key_space  = space_q;
    assign key_left   = left_q;
    assign key_right  = right_q;
    assign scan_code  = scan_code_q;
    assign scan_valid = scan_valid_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: serialises PS/2 frames and checks decoded key state.
// Define PS2_TIMEOUT_EN for the bench as well as the design to exercise the watchdog.
`timescale 1ns/1ps

module tb_ps2_key_decoder;

    localparam int HALF = 20;

    logic       clk;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic       key_space;
    logic       key_left;
    logic       key_right;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       frame_err;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Monitor-owned event counters
    int         sv_cnt      = 0;
    int         err_cnt     = 0;
    int         ks_fall     = 0;
    logic       prev_sv     = 1'b0;
    logic       prev_ks     = 1'b0;
    logic       ks_at_sv    = 1'b0;
    logic       ks_after_sv = 1'b0;
    logic [7:0] last_code   = 8'h00;

    int sv0;
    int err0;
    int fall0;

    ps2_key_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .key_space (key_space),
        .key_left  (key_left),
        .key_right (key_right),
        .scan_code (scan_code),
        .scan_valid(scan_valid),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        prev_sv <= scan_valid;
        prev_ks <= key_space;
        if (!rst) begin
            if (scan_valid) begin
                sv_cnt    <= sv_cnt + 1;
                last_code <= scan_code;
                ks_at_sv  <= key_space;
            end
            if (prev_sv) ks_after_sv <= key_space;
            if (frame_err) err_cnt <= err_cnt + 1;
            if (prev_ks && !key_space) ks_fall <= ks_fall + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] frame(input logic [7:0] d, input logic bad_par,
                                          input logic bad_stop);
        return {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_bits(frame(d, 1'b0, 1'b0), 11);
    endtask

    task automatic snap();
        @(negedge clk);
        sv0   = sv_cnt;
        err0  = err_cnt;
        fall0 = ks_fall;
    endtask

    initial begin
        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_outputs", {20'd0, key_space, key_left, key_right, scan_valid, frame_err,
                                3'd0, scan_code}, 32'd0);
        rst = 1'b0;
        repeat (HALF) @(negedge clk);

        // Space make with latency check
        snap();
        send_byte(8'h29);
        check("space_sv_count", sv_cnt - sv0, 1);
        check("space_code", last_code, 8'h29);
        check("space_lat_n1", ks_at_sv, 1'b0);
        check("space_lat_n2", ks_after_sv, 1'b1);
        check("space_make", key_space, 1'b1);

        // Reset in the middle of a frame
        send_bits(frame(8'h74, 1'b0, 1'b0), 5);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mid_outputs", {20'd0, key_space, key_left, key_right, scan_valid, frame_err,
                                  3'd0, scan_code}, 32'd0);
        rst = 1'b0;
        repeat (HALF) @(negedge clk);
        snap();
        send_byte(8'h29);
        check("post_rst_space", key_space, 1'b1);
        check("post_rst_code", scan_code, 8'h29);
        check("post_rst_no_err", err_cnt - err0, 0);

        // Break, then typematic repeats
        snap();
        send_byte(8'hF0);
        send_byte(8'h29);
        check("space_break", key_space, 1'b0);
        check("space_break_fall", ks_fall - fall0, 1);
        snap();
        send_byte(8'h29);
        send_byte(8'h29);
        send_byte(8'h29);
        check("repeat_space", key_space, 1'b1);
        check("repeat_no_glitch", ks_fall - fall0, 0);
        check("repeat_sv_count", sv_cnt - sv0, 3);

        // Arrows held independently
        send_byte(8'hE0);
        send_byte(8'h6B);
        check("left_make", key_left, 1'b1);
        send_byte(8'hE0);
        send_byte(8'h74);
        check("right_make", key_right, 1'b1);
        check("left_still", key_left, 1'b1);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h6B);
        check("left_break", key_left, 1'b0);
        check("right_kept", key_right, 1'b1);

        // Keypad 4 must not alias the left arrow
        snap();
        send_byte(8'h6B);
        check("kp4_left", key_left, 1'b0);
        check("kp4_code", scan_code, 8'h6B);
        check("kp4_sv", sv_cnt - sv0, 1);

        // Framing errors
        send_byte(8'hF0);
        send_byte(8'h29);
        check("space_cleared", key_space, 1'b0);
        snap();
        send_bits(frame(8'h29, 1'b1, 1'b0), 11);
        check("badpar_err", err_cnt - err0, 1);
        check("badpar_no_sv", sv_cnt - sv0, 0);
        check("badpar_space", key_space, 1'b0);
        snap();
        send_bits(frame(8'h74, 1'b0, 1'b1), 11);
        check("badstop_err", err_cnt - err0, 1);
        check("badstop_code", scan_code, 8'h29);
        check("badstop_right", key_right, 1'b1);
        snap();
        send_byte(8'hE0);
        send_bits(frame(8'h6B, 1'b1, 1'b0), 11);
        send_byte(8'h6B);
        check("ext_abort_err", err_cnt - err0, 1);
        check("ext_abort_left", key_left, 1'b0);

        // Short clock glitch is filtered out
        ps2_clk = 1'b0;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        snap();
        send_byte(8'h29);
        check("glitch_no_err", err_cnt - err0, 0);
        check("glitch_sv", sv_cnt - sv0, 1);
        check("glitch_space", key_space, 1'b1);

`ifdef PS2_TIMEOUT_EN
        snap();
        send_bits(frame(8'h74, 1'b0, 1'b0), 5);
        repeat (40_100) @(negedge clk);
        check("timeout_err", err_cnt - err0, 1);
        check("timeout_keys", {key_space, key_left, key_right}, 3'b101);
        snap();
        send_byte(8'h29);
        check("timeout_recover_sv", sv_cnt - sv0, 1);
        check("timeout_recover_code", scan_code, 8'h29);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
